// File: rtl/fetch_controller_if.sv
// fetch_controller_if
//   Bundles the program-memory read path and the instruction stream toward
//   the decoder.
//   Signals:
//     mem_addr    : fetch address to the asynchronous-read program memory
//     mem_data    : instruction word returned combinationally for mem_addr
//     instr_valid : queue head holds a valid instruction
//     instr_ready : decoder accepts the head this cycle
//     instr_data  : head instruction word
//     instr_pc    : address of the head instruction
//   Modports:
//     master : the fetch controller
//     slave  : memory + decoder side (testbench or surrounding core)
interface fetch_controller_if #(
   parameter int prog_mem_length = 8,
   parameter int prog_mem_width  = 13
);
   logic [prog_mem_length-1:0] mem_addr;
   logic [prog_mem_width-1:0]  mem_data;
   logic                       instr_valid;
   logic                       instr_ready;
   logic [prog_mem_width-1:0]  instr_data;
   logic [prog_mem_length-1:0] instr_pc;

   modport master (
      output mem_addr, instr_valid, instr_data, instr_pc,
      input  mem_data, instr_ready
   );

   modport slave (
      input  mem_addr, instr_valid, instr_data, instr_pc,
      output mem_data, instr_ready
   );
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller
//   Instruction fetch unit. It walks a fetch pointer through an
//   asynchronous-read program memory and buffers {instruction, pc} pairs in
//   a 2-entry queue for the decoder. Redirects retarget the pointer and
//   flush the queue.
//   Ports:
//     clk            : single clock, rising edge
//     rst_n          : asynchronous active-low reset
//     start          : leave IDLE/HALT and begin fetching
//     halt_req       : stop issuing new fetches (RUN -> HALT)
//     redirect_valid : jump/branch request, highest priority
//     redirect_addr  : jump target
//     halted         : in HALT with an empty queue
//     bus            : memory read path and decoder stream (master side)
module fetch_controller #(
   parameter int                         prog_mem_length = 8,
   parameter int                         prog_mem_width  = 13,
   parameter logic [prog_mem_length-1:0] RESET_VECTOR    = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       halt_req,
   input  logic                       redirect_valid,
   input  logic [prog_mem_length-1:0] redirect_addr,
   output logic                       halted,
   fetch_controller_if.master         bus
);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   typedef struct packed {
      logic [prog_mem_width-1:0]  instr;
      logic [prog_mem_length-1:0] pc;
   } entry_t;

   state_t                     state;
   logic [prog_mem_length-1:0] pc_fetch;
   logic [1:0]                 count;
   // Entry 0 is always the head; entry 1 is only meaningful when count=2.
   entry_t                     fifo [2];
   entry_t                     fetched;
   logic                       push;
   logic                       pop;

   assign bus.mem_addr    = pc_fetch;
   assign bus.instr_valid = (count != 2'd0);
   assign bus.instr_data  = fifo[0].instr;
   assign bus.instr_pc    = fifo[0].pc;
   assign halted          = (state == HALT) && (count == 2'd0);

   assign fetched = '{instr: bus.mem_data, pc: pc_fetch};
   assign pop     = bus.instr_valid && bus.instr_ready;
   // A full queue can still accept a push when the head leaves this cycle.
   assign push    = (state == RUN) && !redirect_valid && !halt_req &&
                    ((count != 2'd2) || pop);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc_fetch <= RESET_VECTOR;
         count    <= 2'd0;
         // NOTE: the queue storage is reset too, because instr_data/instr_pc
         // are read straight from entry 0 and must be zero during reset.
         fifo[0]  <= '0;
         fifo[1]  <= '0;
      end else begin
         case (state)
            IDLE, HALT: if (start)    state <= RUN;
            RUN:        if (halt_req) state <= HALT;
            default:                  state <= IDLE;
         endcase

         if (redirect_valid) begin
            // Flush; a head popped in this same cycle is already consumed.
            pc_fetch <= redirect_addr;
            count    <= 2'd0;
         end else begin
            if (push) pc_fetch <= pc_fetch + 1'b1;
            case ({push, pop})
               2'b10: begin
                  if (count == 2'd0) fifo[0] <= fetched;
                  else               fifo[1] <= fetched;
                  count <= count + 2'd1;
               end
               2'b01: begin
                  fifo[0] <= fifo[1];
                  count   <= count - 2'd1;
               end
               2'b11: begin
                  if (count == 2'd2) begin
                     fifo[0] <= fifo[1];
                     fifo[1] <= fetched;
                  end else begin
                     fifo[0] <= fetched;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller
//   Self-checking bench for fetch_controller. A random program memory model
//   answers mem_addr combinationally; expected {pc, data} pairs are queued
//   when stimulus is driven and compared at every decoder handshake.
module tb_fetch_controller;
   localparam int L = 8;
   localparam int W = 13;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         halt_req;
   logic         redirect_valid;
   logic [L-1:0] redirect_addr;
   logic         halted;

   fetch_controller_if #(.prog_mem_length(L), .prog_mem_width(W)) bus ();

   fetch_controller #(.prog_mem_length(L), .prog_mem_width(W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .halt_req       (halt_req),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .halted         (halted),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   logic [W-1:0] mem [256];
   assign bus.mem_data = mem[bus.mem_addr];

   typedef struct {
      logic [L-1:0] pc;
      logic [W-1:0] data;
   } exp_t;
   exp_t sb [$];

   typedef struct {
      logic         start;
      logic         halt;
      logic         ready;
      logic         valid;
      logic [L-1:0] pc;
      logic [L-1:0] addr;
      logic         halted;
   } vec_t;
   vec_t vecs [7];

   int checks = 0;
   int errors = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_pc(logic [L-1:0] pc);
      exp_t e;
      e.pc   = pc;
      e.data = mem[pc];
      sb.push_back(e);
   endtask

   // Called at a falling edge with inputs already set; compares any
   // handshake that the next rising edge will complete, then advances.
   task automatic cycle();
      exp_t e;
      #1;
      if (bus.instr_valid && bus.instr_ready) begin
         check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("deliver_pc", 32'(bus.instr_pc), 32'(e.pc));
            check("deliver_data", 32'(bus.instr_data), 32'(e.data));
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain(string name);
      bus.instr_ready = 1'b1;
      for (int i = 0; i < 20 && sb.size() != 0; i++) cycle();
      bus.instr_ready = 1'b0;
      check({name, "_drained"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = W'($urandom);
      rst_n           = 1'b0;
      start           = 1'b0;
      halt_req        = 1'b0;
      redirect_valid  = 1'b0;
      redirect_addr   = '0;
      bus.instr_ready = 1'b0;

      // start halt ready | valid pc addr halted
      vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 8'h02, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 8'h03, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 8'h04, 1'b0};
      vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 1'b1};

      // Reset state
      @(negedge clk);
      check("rst_valid", 32'(bus.instr_valid), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_data", 32'(bus.instr_data), 32'd0);
      check("rst_pc", 32'(bus.instr_pc), 32'd0);
      check("rst_addr", 32'(bus.mem_addr), 32'd0);
      rst_n = 1'b1;
      cycle();

      // Start, stream 0..3, halt
      for (int i = 0; i < 4; i++) expect_pc(L'(i));
      for (int i = 0; i < 7; i++) begin
         start           = vecs[i].start;
         halt_req        = vecs[i].halt;
         bus.instr_ready = vecs[i].ready;
         #1;
         check($sformatf("vec%0d_valid", i), 32'(bus.instr_valid), 32'(vecs[i].valid));
         check($sformatf("vec%0d_addr", i), 32'(bus.mem_addr), 32'(vecs[i].addr));
         check($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].halted));
         if (vecs[i].valid)
            check($sformatf("vec%0d_pc", i), 32'(bus.instr_pc), 32'(vecs[i].pc));
         cycle();
      end
      check("vec_sb_empty", 32'(sb.size()), 32'd0);

      // Stall with full queue, then halt while draining
      start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      cycle();
      for (int i = 0; i < 5; i++) begin
         #1;
         check("stall_valid", 32'(bus.instr_valid), 32'd1);
         check("stall_pc", 32'(bus.instr_pc), 32'h04);
         check("stall_data", 32'(bus.instr_data), 32'(mem[4]));
         check("stall_addr", 32'(bus.mem_addr), 32'h06);
         cycle();
      end
      expect_pc(8'h04);
      expect_pc(8'h05);
      halt_req        = 1'b1;
      bus.instr_ready = 1'b1;
      cycle();
      halt_req = 1'b0;
      #1;
      check("halt_drain_halted", 32'(halted), 32'd0);
      check("halt_drain_pc", 32'(bus.instr_pc), 32'h05);
      cycle();
      #1;
      check("halt_done_halted", 32'(halted), 32'd1);
      check("halt_done_valid", 32'(bus.instr_valid), 32'd0);
      check("halt_done_addr", 32'(bus.mem_addr), 32'h06);
      check("halt_sb_empty", 32'(sb.size()), 32'd0);
      bus.instr_ready = 1'b0;

      // Resume sequentially, fill, redirect with a same-cycle pop
      start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      cycle();
      #1;
      check("resume_pc", 32'(bus.instr_pc), 32'h06);
      expect_pc(8'h06);
      redirect_valid  = 1'b1;
      redirect_addr   = 8'h40;
      bus.instr_ready = 1'b1;
      cycle();
      redirect_valid  = 1'b0;
      bus.instr_ready = 1'b0;
      #1;
      check("redir_flush_valid", 32'(bus.instr_valid), 32'd0);
      check("redir_addr", 32'(bus.mem_addr), 32'h40);
      cycle();
      #1;
      check("redir_valid", 32'(bus.instr_valid), 32'd1);
      check("redir_pc", 32'(bus.instr_pc), 32'h40);
      expect_pc(8'h40);
      expect_pc(8'h41);
      drain("redir");

      // Wrap 0xFE -> 0x01
      redirect_valid = 1'b1;
      redirect_addr  = 8'hFE;
      cycle();
      redirect_valid = 1'b0;
      expect_pc(8'hFE);
      expect_pc(8'hFF);
      expect_pc(8'h00);
      expect_pc(8'h01);
      drain("wrap");

      // Asynchronous reset with a full queue
      cycle();
      cycle();
      #1;
      check("prerst_valid", 32'(bus.instr_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(bus.instr_valid), 32'd0);
      check("async_rst_pc", 32'(bus.instr_pc), 32'd0);
      check("async_rst_data", 32'(bus.instr_data), 32'd0);
      check("async_rst_halted", 32'(halted), 32'd0);
      check("async_rst_addr", 32'(bus.mem_addr), 32'd0);
      @(negedge clk);
      rst_n           = 1'b1;
      bus.instr_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("post_rst_valid", 32'(bus.instr_valid), 32'd0);
         check("post_rst_halted", 32'(halted), 32'd0);
         cycle();
      end
      bus.instr_ready = 1'b0;

      // Redirect in IDLE only retargets the pointer
      redirect_valid = 1'b1;
      redirect_addr  = 8'h10;
      cycle();
      redirect_valid = 1'b0;
      #1;
      check("idle_redir_addr", 32'(bus.mem_addr), 32'h10);
      check("idle_redir_valid", 32'(bus.instr_valid), 32'd0);
      check("idle_redir_halted", 32'(halted), 32'd0);
      cycle();
      #1;
      check("idle_still_valid", 32'(bus.instr_valid), 32'd0);
      expect_pc(8'h10);
      expect_pc(8'h11);
      start = 1'b1;
      cycle();
      start = 1'b0;
      drain("idle_start");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter SHALL be prog_mem_length, default 8, program-memory address width (256 words).
REQ-002 Parameter SHALL be prog_mem_width, default 13, instruction word width.
REQ-003 Parameter SHALL be RESET_VECTOR, default 0, first fetch address after reset.
REQ-004 Port SHALL be clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port SHALL be rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port SHALL be start  input  1  leave IDLE/HALT and begin fetching.
REQ-007 Port SHALL be halt_req  input  1  stop issuing new fetches.
REQ-008 Port SHALL be redirect_valid  input  1  jump/branch request.
REQ-009 Port SHALL be redirect_addr  input  prog_mem_length  jump target.
REQ-010 Port SHALL be mem_addr  output  prog_mem_length  address driven to the asynchronous-read program memory.
REQ-011 Port SHALL be mem_data  input  prog_mem_width  instruction returned combinationally for mem_addr.
REQ-012 Port SHALL be instr_valid  output  1  queue head holds a valid instruction.
REQ-013 Port SHALL be instr_ready  input  1  decoder accepts head.
REQ-014 Port SHALL be instr_data  output  prog_mem_width  head instruction.
REQ-015 Port SHALL be instr_pc  output  prog_mem_length  address of head instruction.
REQ-016 Port SHALL be halted  output  1  state HALT and queue empty.

Function
REQ-017 Block SHALL hold fetch pointer pc_fetch and drive mem_addr = pc_fetch combinationally.
REQ-018 Block SHALL contain a 2-entry FIFO of {instruction, pc}; count range 0..2.
REQ-019 FSM SHALL have states IDLE, RUN, HALT.
REQ-020 IDLE/HALT -> RUN SHALL occur on start=1; start in RUN SHALL be ignored.
REQ-021 RUN -> HALT SHALL occur on halt_req=1 (halt_req wins over start when both are high in RUN).
REQ-022 Push SHALL occur in RUN only, when no redirect and (count<2 or pop this cycle): enqueue {mem_data, pc_fetch}, pc_fetch <= pc_fetch+1.
REQ-023 No push SHALL occur in the cycle halt_req causes RUN -> HALT.
REQ-024 pc_fetch increment SHALL wrap modulo 2^prog_mem_length (255 -> 0), with no flag.
REQ-025 Pop SHALL occur when instr_valid & instr_ready; instr_valid = (count!=0).
REQ-026 Simultaneous push and pop at count=2 SHALL keep count=2 with correct order; at count=1 SHALL keep count=1 with the new entry at head.
REQ-027 instr_data/instr_pc SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-028 Redirect SHALL have highest priority in every state: pc_fetch <= redirect_addr, FIFO flushed (count <= 0), no push that cycle; a pop that same cycle counts as consumed.
REQ-029 Redirect SHALL NOT change FSM state (redirect in HALT or IDLE only retargets pc_fetch).
REQ-030 In HALT, queued entries SHALL still drain via pops; halted=1 once count=0.
REQ-031 Latency: start sampled at edge N -> RUN after N; first push at edge N+1; instr_valid=1 with instr_pc=RESET_VECTOR after edge N+1.
REQ-032 Steady state with instr_ready=1 SHALL deliver one instruction per cycle, consecutive pc.

Reset
REQ-033 rst_n=0 SHALL immediately force state IDLE, pc_fetch=RESET_VECTOR, count=0, instr_valid=0, halted=0, instr_data=0, instr_pc=0.
REQ-034 Reset asserted mid-operation SHALL discard all queued entries and any in-flight redirect; operation resumes only after start.

Verification
REQ-035 Reset, start pulse, instr_ready=1 -> instr_pc sequence 0,1,2,3 on consecutive cycles, instr_data equals memory words 0..3.
REQ-036 instr_ready=0 for 5 cycles in RUN -> count saturates at 2, pc_fetch stops at head+2, head stable; release -> no instruction lost or duplicated.
REQ-037 redirect_valid with redirect_addr=0x40 while count=2 -> next cycle instr_valid=0; following cycle instr_pc=0x40.
REQ-038 Run from pc_fetch=0xFE -> delivered instr_pc 0xFE, 0xFF, 0x00, 0x01.
REQ-039 halt_req with count=2, instr_ready=1 -> two more instructions delivered, then halted=1; start -> fetch resumes at next sequential pc.
REQ-040 rst_n dropped asynchronously mid-stream with count=2 -> outputs zero before next clock edge; after release no instr_valid until start.
